v_safe_fsm_input_cond: RTL and testbench

//  Input conditioning stage that feeds the one-hot safe control FSM. It produces that FSM's
//  c[3:0] control and d[3:0] data inputs from asynchronous, bouncy control lines and a

---
 rtl/v_safe_fsm_input_cond_pkg.sv | 16 +
 rtl/v_safe_fsm_input_cond_if.sv | 9 +
 rtl/v_safe_fsm_db_bit.sv | 45 ++++
 rtl/v_safe_fsm_input_cond.sv | 100 ++++++++++
 tb/tb_v_safe_fsm_input_cond.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/v_safe_fsm_input_cond_pkg.sv
// Shared types and constants for the safe FSM input conditioning stage.
// Holds the one-hot data FSM encodings and the counter width.
package v_safe_fsm_input_cond_pkg;

  localparam int unsigned CNT_W = 4;

  // The recovery state is the target of every illegal encoding.
  localparam logic [2:0] SAFE_RECOVERY_STATE = 3'b100;

  typedef enum logic [2:0] {
    StIdle    = 3'b001,
    StHold    = 3'b010,
    StRecover = SAFE_RECOVERY_STATE
  } state_e;

endpackage

// File: rtl/v_safe_fsm_input_cond_if.sv
// Valid/ready data source handshake feeding the conditioning stage.
interface v_safe_fsm_input_cond_if;
  logic [3:0] d_in;
  logic       d_valid;
  logic       d_ready;

  modport master (output d_in, output d_valid, input d_ready);
  modport slave  (input d_in, input d_valid, output d_ready);
endinterface

// File: rtl/v_safe_fsm_db_bit.sv
// Single-bit synchroniser followed by a mismatch-count debouncer.
module v_safe_fsm_db_bit
  import v_safe_fsm_input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_c;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];
  assign o_c = r_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // c only moves after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_c   <= 1'b0;
    end else if (w_s == r_c) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
      r_c   <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/v_safe_fsm_input_cond.sv
// Conditions c/d inputs for the one-hot safe control FSM: debounced controls plus a
// held data word accepted by a one-hot FSM with a recovery state.
module v_safe_fsm_input_cond
  import v_safe_fsm_input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     i_c_raw,
  v_safe_fsm_input_cond_if.slave         io_src,
  output logic [3:0]                     o_c,
  output logic [3:0]                     o_d,
  output logic                           o_d_upd,
  output logic                           o_err
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    v_safe_fsm_db_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .i_raw (i_c_raw[gi]),
      .o_c   (o_c[gi])
    );
  end

  (* fsm_encoding = "user", safe_implementation = "yes", safe_recovery_state = "100" *)
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_hcnt;
  logic [3:0]       r_d;
  logic             r_d_upd;
  logic             r_err;
  logic             w_accept;

  assign o_d     = r_d;
  assign o_d_upd = r_d_upd;
  assign o_err   = r_err;

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    io_src.d_ready = 1'b0;
    case (r_state)
      StIdle: begin
        io_src.d_ready = 1'b1;
        if (io_src.d_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        if (r_hcnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_state_nxt = StIdle;
        end
      end
      StRecover: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StRecover;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt  <= '0;
      r_d     <= '0;
      r_d_upd <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_d_upd <= w_accept;
      if (w_accept) begin
        r_d    <= io_src.d_in;
        r_hcnt <= '0;
      end else if (r_state == StHold) begin
        r_hcnt <= r_hcnt + CNT_W'(1);
      end
      // Sticky flag raised on the way into recovery, visible during the recovery cycle.
      if (w_state_nxt == StRecover) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_v_safe_fsm_input_cond.sv
// Self-checking bench: directed scenarios with literal expectations, then random stimulus
// compared every cycle against a delay-line / countdown model of the stage.
module tb_v_safe_fsm_input_cond;
  import v_safe_fsm_input_cond_pkg::*;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int HC = 3;

  logic       clk;
  logic       rst;
  logic [3:0] c_raw;
  logic [3:0] o_c;
  logic [3:0] o_d;
  logic       o_d_upd;
  logic       o_err;

  v_safe_fsm_input_cond_if sif ();

  v_safe_fsm_input_cond #(
    .SYNC_STAGES (SS),
    .DB_CYCLES   (DB),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_c_raw (c_raw),
    .io_src  (sif),
    .o_c     (o_c),
    .o_d     (o_d),
    .o_d_upd (o_d_upd),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit inj_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: controls are raw samples delayed SS edges then accepted after DB agreeing
  // mismatches; data path is a "busy" countdown of HC cycles after each accepted word.
  logic [3:0] m_hist [SS];
  logic [3:0] m_c;
  int         m_cnt [4];
  logic [3:0] m_d;
  logic       m_upd;
  logic       m_err;
  int         m_busy;
  bit         m_live = 1'b0;

  initial begin
    logic       cap_rst, cap_v, cap_inj;
    logic [3:0] cap_raw, cap_din, s;
    forever begin
      @(posedge clk);
      cap_rst = rst;
      cap_raw = c_raw;
      cap_v   = sif.d_valid;
      cap_din = sif.d_in;
      cap_inj = inj_pending;
      if (cap_rst) begin
        for (int j = 0; j < SS; j++) m_hist[j] = 4'h0;
        for (int b = 0; b < 4; b++) m_cnt[b] = 0;
        m_c = 4'h0; m_d = 4'h0; m_upd = 1'b0; m_err = 1'b0; m_busy = 0;
        m_live = 1'b1;
      end else if (m_live) begin
        s = m_hist[SS-1];
        for (int j = SS - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = cap_raw;
        for (int b = 0; b < 4; b++) begin
          if (s[b] == m_c[b]) m_cnt[b] = 0;
          else if (m_cnt[b] == DB - 1) begin
            m_c[b] = s[b];
            m_cnt[b] = 0;
          end else m_cnt[b]++;
        end
        m_upd = 1'b0;
        if (cap_inj) begin
          m_err = 1'b1;
          m_busy = 1;
          inj_pending = 1'b0;
        end else if (m_busy == 0 && cap_v) begin
          m_d = cap_din;
          m_upd = 1'b1;
          m_busy = HC;
        end else if (m_busy > 0) begin
          m_busy--;
        end
      end
      #1;
      if (m_live) begin
        chk("model_c", 32'(o_c), 32'(m_c));
        chk("model_d", 32'(o_d), 32'(m_d));
        chk("model_d_upd", 32'(o_d_upd), 32'(m_upd));
        chk("model_err", 32'(o_err), 32'(m_err));
        chk("model_d_ready", 32'(sif.d_ready), 32'(m_busy == 0));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; c_raw = 4'h0; sif.d_valid = 1'b0; sif.d_in = 4'h0;
    cyc();
    rst = 1'b0;
    chk("reset_c", 32'(o_c), 32'h0);
    chk("reset_d", 32'(o_d), 32'h0);
    chk("reset_err", 32'(o_err), 32'h0);
    chk("reset_ready", 32'(sif.d_ready), 32'h1);

    // Clean step: c follows after edge 5.
    c_raw = 4'b0101;
    for (int k = 0; k <= 5; k++) begin
      cyc();
      chk("step_latency", 32'(o_c), (k < 5) ? 32'h0 : 32'h5);
    end
    c_raw = 4'h0;
    repeat (8) cyc();

    // 3-cycle glitch rejected, 4-cycle pulse accepted on schedule.
    c_raw = 4'b0100;
    repeat (3) cyc();
    c_raw = 4'h0;
    repeat (8) cyc();
    chk("short_pulse", 32'(o_c[2]), 32'h0);
    c_raw = 4'b0100;
    for (int k = 0; k <= 5; k++) begin
      cyc();
      if (k == 3) c_raw = 4'h0;
      if (k == 4) chk("pulse4_before", 32'(o_c[2]), 32'h0);
      if (k == 5) chk("pulse4_after", 32'(o_c[2]), 32'h1);
    end
    repeat (6) cyc();

    // Back-to-back accepts with d_valid held.
    sif.d_valid = 1'b1; sif.d_in = 4'hA;
    cyc();
    chk("acc_a_d", 32'(o_d), 32'hA);
    chk("acc_a_upd", 32'(o_d_upd), 32'h1);
    chk("acc_a_ready", 32'(sif.d_ready), 32'h0);
    sif.d_in = 4'h3;
    cyc();
    chk("hold1_upd", 32'(o_d_upd), 32'h0);
    chk("hold1_d", 32'(o_d), 32'hA);
    cyc();
    chk("hold2_ready", 32'(sif.d_ready), 32'h0);
    cyc();
    chk("idle_ready", 32'(sif.d_ready), 32'h1);
    chk("idle_d", 32'(o_d), 32'hA);
    cyc();
    chk("acc_3_d", 32'(o_d), 32'h3);
    chk("acc_3_upd", 32'(o_d_upd), 32'h1);
    sif.d_valid = 1'b0;
    repeat (5) cyc();

    // Illegal encoding forced into the state register.
    force dut.r_state = state_e'(3'b011);
    inj_pending = 1'b1;
    #1;
    release dut.r_state;
    #1;
    chk("illegal_ready", 32'(sif.d_ready), 32'h0);
    cyc();
    chk("recover_err", 32'(o_err), 32'h1);
    chk("recover_ready", 32'(sif.d_ready), 32'h0);
    chk("recover_d", 32'(o_d), 32'h3);
    cyc();
    chk("post_recover_ready", 32'(sif.d_ready), 32'h1);
    repeat (5) cyc();
    chk("err_sticky", 32'(o_err), 32'h1);

    // Reset during HOLD and mid-debounce.
    c_raw = 4'b1111; sif.d_valid = 1'b1; sif.d_in = 4'h5;
    repeat (3) cyc();
    rst = 1'b1; sif.d_valid = 1'b0;
    cyc();
    rst = 1'b0;
    chk("midrst_c", 32'(o_c), 32'h0);
    chk("midrst_d", 32'(o_d), 32'h0);
    chk("midrst_ready", 32'(sif.d_ready), 32'h1);
    chk("midrst_err", 32'(o_err), 32'h0);

    // Random traffic, controls biased toward stable runs.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) c_raw[b] = ~c_raw[b];
      sif.d_valid = ($urandom_range(0, 2) != 0);
      sif.d_in    = 4'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; sif.d_valid = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
